// File: rtl/i2c.sv
// i2c: bus-mapped I2C master; runs START, address byte, N data bytes, STOP from an internal byte buffer.
// Latency: bus read data one BUS_CLK after BUS_RD; every I2C bit spans 4 ticks; lines lag the FSM by one cycle.
// Backpressure: none on the bus; START/ADDR/SIZE/buffer writes while busy are dropped. Define I2C_INT_CLKDIV_EN for an internal tick divider.
module i2c #(
    parameter int                   ABUSWIDTH = 16,
    parameter logic [ABUSWIDTH-1:0] BASEADDR  = '0,
    parameter logic [ABUSWIDTH-1:0] HIGHADDR  = '0,
    parameter int                   MEM_BYTES = 1,
    parameter int                   CLKDIV    = 4
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    inout  wire  [7:0]           BUS_DATA,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    input  logic                 I2C_CLK,
    inout  wire                  I2C_SDA,
    inout  wire                  I2C_SCL
);

    localparam int                   IW     = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [15:0]          MEMB   = 16'(MEM_BYTES);
    localparam logic [ABUSWIDTH-1:0] BUF_LO = ABUSWIDTH'(16);
    localparam logic [ABUSWIDTH-1:0] BUF_HI = ABUSWIDTH'(16 + MEM_BYTES);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RACK, S_STOP
    } state_t;

    state_t               state, state_nxt;
    logic [ABUSWIDTH-1:0] off;
    logic [IW-1:0]        buf_off;
    logic                 hit, sel_ver, sel_ctl, sel_addr, sel_szl, sel_szh, sel_buf;
    logic                 rst, soft_rst, start_req, cfg_wr;
    logic                 done, no_ack;
    logic [7:0]           addr_reg;
    logic [15:0]          size_reg, n_eff, idx, nidx;
    logic                 last;
    logic [7:0]           mem [MEM_BYTES];
    logic [7:0]           rd_mux, rd_dat;
    logic                 rd_vld;
    logic                 tick, bit_end;
    logic [1:0]           ph;
    logic [2:0]           cnt;
    logic [7:0]           shift;
    logic                 samp;
    logic                 scl_low_c, sda_low_c, scl_drv, sda_drv;

    // Address decode relative to BASEADDR
    assign hit      = (BUS_ADD >= BASEADDR) && (BUS_ADD <= HIGHADDR);
    assign off      = BUS_ADD - BASEADDR;
    assign buf_off  = IW'(off - BUF_LO);
    assign sel_ver  = hit && (off == ABUSWIDTH'(0));
    assign sel_ctl  = hit && (off == ABUSWIDTH'(1));
    assign sel_addr = hit && (off == ABUSWIDTH'(2));
    assign sel_szl  = hit && (off == ABUSWIDTH'(3));
    assign sel_szh  = hit && (off == ABUSWIDTH'(4));
    assign sel_buf  = hit && (off >= BUF_LO) && (off < BUF_HI);

    // A write to the version register acts exactly like BUS_RST
    assign soft_rst  = BUS_WR && sel_ver;
    assign rst       = BUS_RST || soft_rst;
    assign cfg_wr    = BUS_WR && done && !rst;
    assign start_req = cfg_wr && sel_ctl;

    assign n_eff = (size_reg > MEMB) ? MEMB : size_reg;
    assign last  = (idx == n_eff - 16'd1);
    assign nidx  = idx + 16'd1;

`ifdef I2C_INT_CLKDIV_EN
    logic [15:0] div_cnt;

    // Internal tick: one BUS_CLK-wide pulse every CLKDIV cycles
    always_ff @(posedge BUS_CLK) begin
        if (rst || div_cnt == 16'(CLKDIV - 1)) div_cnt <= 16'd0;
        else                                    div_cnt <= div_cnt + 16'd1;
    end
    assign tick = (div_cnt == 16'(CLKDIV - 1));
`else
    logic [2:0] clk_sync;

    // Two-flop synchroniser on I2C_CLK plus one flop for rising-edge detect
    always_ff @(posedge BUS_CLK) begin
        if (rst) clk_sync <= 3'b000;
        else     clk_sync <= {clk_sync[1:0], I2C_CLK};
    end
    assign tick = clk_sync[1] && !clk_sync[2];
`endif

    assign bit_end = tick && (ph == 2'd3);

    // Configuration registers; frozen while a transfer is running
    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            addr_reg <= 8'h00;
            size_reg <= 16'h0000;
        end else if (cfg_wr) begin
            if (sel_addr) addr_reg       <= BUS_DATA;
            if (sel_szl)  size_reg[7:0]  <= BUS_DATA;
            if (sel_szh)  size_reg[15:8] <= BUS_DATA;
        end
    end

    // DONE / NO_ACK status flags
    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            done   <= 1'b1;
            no_ack <= 1'b0;
        end else if (start_req) begin
            done   <= 1'b0;
            no_ack <= 1'b0;
        end else begin
            if (bit_end && (state == S_AACK || state == S_WACK) && samp) no_ack <= 1'b1;
            if (bit_end && state == S_STOP)                              done   <= 1'b1;
        end
    end

    // Byte buffer: filled by the bus when idle, by received bytes during a read
    always_ff @(posedge BUS_CLK) begin
        if (!rst && state == S_RDATA && bit_end && cnt == 3'd7) mem[idx[IW-1:0]] <= shift;
        else if (cfg_wr && sel_buf)                              mem[buf_off]      <= BUS_DATA;
    end

    // Bus read mux
    always_comb begin
        rd_mux = 8'h00;
        if (sel_ver)       rd_mux = 8'h01;
        else if (sel_ctl)  rd_mux = {6'b0, no_ack, done};
        else if (sel_addr) rd_mux = addr_reg;
        else if (sel_szl)  rd_mux = size_reg[7:0];
        else if (sel_szh)  rd_mux = size_reg[15:8];
        else if (sel_buf)  rd_mux = mem[buf_off];
    end

    // Read return register: data valid for exactly one cycle after BUS_RD
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            rd_vld <= 1'b0;
            rd_dat <= 8'h00;
        end else begin
            rd_vld <= BUS_RD && hit;
            rd_dat <= rd_mux;
        end
    end
    assign BUS_DATA = rd_vld ? rd_dat : 8'hzz;

    // FSM state register
    always_ff @(posedge BUS_CLK) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state: every move except IDLE->START happens at the end of a bit
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_req) state_nxt = S_START;
            S_START: if (bit_end) state_nxt = S_ADDR;
            S_ADDR:  if (bit_end && cnt == 3'd7) state_nxt = S_AACK;
            S_AACK:  if (bit_end) begin
                         if (samp || n_eff == 16'd0) state_nxt = S_STOP;
                         else if (addr_reg[0])       state_nxt = S_RDATA;
                         else                        state_nxt = S_WDATA;
                     end
            S_WDATA: if (bit_end && cnt == 3'd7) state_nxt = S_WACK;
            S_WACK:  if (bit_end) state_nxt = (samp || last) ? S_STOP : S_WDATA;
            S_RDATA: if (bit_end && cnt == 3'd7) state_nxt = S_RACK;
            S_RACK:  if (bit_end) state_nxt = last ? S_STOP : S_RDATA;
            S_STOP:  if (bit_end) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bit datapath: tick phase, bit counter, shift register, SDA sample at tick 2
    always_ff @(posedge BUS_CLK) begin
        if (rst || state == S_IDLE) begin
            ph   <= 2'd0;
            cnt  <= 3'd0;
            idx  <= 16'd0;
            samp <= 1'b1;
        end else if (tick) begin
            ph <= ph + 2'd1;
            if (ph == 2'd1) begin
                samp <= I2C_SDA;
                if (state == S_RDATA) shift <= {shift[6:0], I2C_SDA};
            end
            if (ph == 2'd3) begin
                cnt <= (state == S_ADDR || state == S_WDATA || state == S_RDATA) ? cnt + 3'd1 : 3'd0;
                case (state)
                    S_START:         shift <= addr_reg;
                    S_ADDR, S_WDATA: shift <= {shift[6:0], 1'b0};
                    S_AACK:          shift <= mem[0];
                    S_WACK: begin
                        idx   <= nidx;
                        shift <= mem[nidx[IW-1:0]];
                    end
                    S_RACK:          idx <= nidx;
                    default: ;
                endcase
            end
        end
    end

    // FSM outputs: which line to pull low in the current state and phase
    always_comb begin
        scl_low_c = 1'b0;
        sda_low_c = 1'b0;
        case (state)
            S_START: begin
                scl_low_c = (ph == 2'd3);
                sda_low_c = (ph >= 2'd2);
            end
            S_ADDR, S_WDATA: begin
                scl_low_c = (ph == 2'd0) || (ph == 2'd3);
                sda_low_c = !shift[7];
            end
            S_AACK, S_WACK, S_RDATA: scl_low_c = (ph == 2'd0) || (ph == 2'd3);
            S_RACK: begin
                scl_low_c = (ph == 2'd0) || (ph == 2'd3);
                sda_low_c = !last;
            end
            S_STOP: begin
                scl_low_c = (ph == 2'd0);
                sda_low_c = (ph <= 2'd1);
            end
            default: ;
        endcase
    end

    // Registered open-drain drivers so a reset releases both lines on the next cycle
    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            scl_drv <= 1'b0;
            sda_drv <= 1'b0;
        end else begin
            scl_drv <= scl_low_c;
            sda_drv <= sda_low_c;
        end
    end
    assign I2C_SCL = scl_drv ? 1'b0 : 1'bz;
    assign I2C_SDA = sda_drv ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c.sv
// tb_i2c: directed bench for the i2c master with a byte-addressed slave model at 7'h49.
// Latency: I2C_CLK = BUS_CLK/4, so each I2C bit is 16 BUS_CLK cycles.
// Backpressure: completion is polled through the status register with a bounded loop.
`timescale 1ns/1ps
module tb_i2c;
    logic        clk = 1'b0, rst = 1'b1, rd = 1'b0, wr = 1'b0, i2c_clk = 1'b0;
    logic [15:0] add = 16'h0000;
    logic [7:0]  tb_dat = 8'h00;
    logic        tb_oe = 1'b0;
    wire  [7:0]  bus_data;
    wire         sda, scl;
    logic        s_sda_low = 1'b0;
    int          n_vec = 0, n_err = 0;

    pullup (sda);
    pullup (scl);
    assign bus_data = tb_oe ? tb_dat : 8'hzz;
    assign sda      = s_sda_low ? 1'b0 : 1'bz;

    i2c #(.ABUSWIDTH(16), .BASEADDR(16'h0000), .HIGHADDR(16'h001F), .MEM_BYTES(4), .CLKDIV(4)) dut (
        .BUS_CLK(clk), .BUS_RST(rst), .BUS_ADD(add), .BUS_DATA(bus_data),
        .BUS_RD(rd), .BUS_WR(wr), .I2C_CLK(i2c_clk), .I2C_SDA(sda), .I2C_SCL(scl)
    );

    always #5  clk     = ~clk;
    always #20 i2c_clk = ~i2c_clk;

    // ---------------- slave model ----------------
    logic [7:0] smem [256];
    logic [7:0] s_sh = 8'h00, s_tx = 8'h00, s_ptr = 8'h00;
    logic       s_first = 1'b0, s_rw = 1'b0, s_have_ptr = 1'b0, s_last_mack = 1'b1;
    logic       s_prev_scl = 1'b1, s_prev_sda = 1'b1, s_stop_seen = 1'b0;
    logic       s_mack [4];
    int         s_phase = 4, s_bits = 0, s_tbits = 0;
    int         s_rises = 0, s_rx_bytes = 0, s_mack_n = 0;

    always @(negedge clk) begin
        if (scl === 1'b1 && s_prev_scl && s_prev_sda && sda === 1'b0) begin
            s_phase = 0; s_bits = 0; s_first = 1'b1; s_have_ptr = 1'b0; s_sda_low = 1'b0;
            s_rises = 0; s_rx_bytes = 0; s_mack_n = 0; s_stop_seen = 1'b0;
        end else if (scl === 1'b1 && s_prev_scl && !s_prev_sda && sda === 1'b1) begin
            s_stop_seen = 1'b1; s_phase = 4; s_sda_low = 1'b0;
        end else if (!s_prev_scl && scl === 1'b1) begin
            s_rises++;
            if (s_phase == 0) begin
                s_sh = {s_sh[6:0], sda}; s_bits++;
            end else if (s_phase == 3) begin
                if (s_mack_n < 4) s_mack[s_mack_n] = sda;
                s_mack_n++; s_last_mack = sda;
            end
        end else if (s_prev_scl && scl === 1'b0) begin
            case (s_phase)
                0: if (s_bits == 8) begin
                       s_bits = 0;
                       if (s_first) begin
                           s_first = 1'b0;
                           if (s_sh[7:1] == 7'h49) begin s_rw = s_sh[0]; s_sda_low = 1'b1; s_phase = 1; end
                           else s_phase = 4;
                       end else begin
                           s_rx_bytes++;
                           if (!s_have_ptr) begin s_ptr = s_sh; s_have_ptr = 1'b1; end
                           else begin smem[s_ptr] = s_sh; s_ptr++; end
                           s_sda_low = 1'b1; s_phase = 1;
                       end
                   end
                1: begin
                       s_sda_low = 1'b0;
                       if (s_rw) begin
                           s_tx = smem[s_ptr]; s_ptr++; s_tbits = 0; s_sda_low = !s_tx[7]; s_phase = 2;
                       end else s_phase = 0;
                   end
                2: begin
                       s_tbits++;
                       if (s_tbits == 8) begin s_sda_low = 1'b0; s_phase = 3; end
                       else s_sda_low = !s_tx[3'(7 - s_tbits)];
                   end
                3: if (!s_last_mack) begin
                       s_tx = smem[s_ptr]; s_ptr++; s_tbits = 0; s_sda_low = !s_tx[7]; s_phase = 2;
                   end else s_phase = 4;
                default: ;
            endcase
        end
        s_prev_scl = (scl === 1'b1);
        s_prev_sda = (sda === 1'b1);
    end

    // ---------------- bus helpers ----------------
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1; add = a; tb_dat = d; tb_oe = 1'b1; wr = 1'b1;
        @(posedge clk); #1; wr = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        @(posedge clk); #1; add = a; rd = 1'b1;
        @(posedge clk); #1; rd = 1'b0; d = bus_data;
    endtask

    task automatic wait_done(output logic ok);
        logic [7:0] st;
        ok = 1'b0;
        for (int i = 0; i < 1500 && !ok; i++) begin
            bus_read(16'd1, st);
            if (st[0]) ok = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [7:0] d;
        rst = 1'b1; repeat (5) @(posedge clk); #1; rst = 1'b0;
        bus_read(16'd0, d);
        n_vec++; if (d !== 8'h01) begin n_err++; $display("FAIL version: got %h want 01", d); end
        bus_read(16'd1, d);
        n_vec++; if (d !== 8'h01) begin n_err++; $display("FAIL reset_status: got %h want 01", d); end
        bus_read(16'd2, d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %h want 00", d); end
        bus_read(16'd4, d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_size_hi: got %h want 00", d); end
        bus_read(16'd5, d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL unmapped_5: got %h want 00", d); end
        n_vec++; if (scl !== 1'b1 || sda !== 1'b1) begin n_err++; $display("FAIL reset_lines: scl=%b sda=%b want 1 1", scl, sda); end
    endtask

    task automatic test_write;
        logic [7:0] d; logic ok;
        bus_write(16'd2, 8'h92); bus_write(16'd3, 8'h03); bus_write(16'd4, 8'h00);
        bus_write(16'd16, 8'h05); bus_write(16'd17, 8'hAA); bus_write(16'd18, 8'hBB);
        bus_write(16'd1, 8'h00);
        bus_read(16'd1, d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL write_busy_status: got %h want 00", d); end
        wait_done(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL write_timeout: done never set"); end
        bus_read(16'd1, d);
        n_vec++; if (d !== 8'h01) begin n_err++; $display("FAIL write_status: got %h want 01", d); end
        n_vec++; if (smem[5] !== 8'hAA || smem[6] !== 8'hBB) begin n_err++; $display("FAIL write_mem: got %h %h want aa bb", smem[5], smem[6]); end
        n_vec++; if (s_rx_bytes != 3 || !s_stop_seen) begin n_err++; $display("FAIL write_bytes: got %0d stop=%b want 3 1", s_rx_bytes, s_stop_seen); end
    endtask

    task automatic test_read;
        logic [7:0] d; logic ok;
        bus_write(16'd2, 8'h92); bus_write(16'd3, 8'h01); bus_write(16'd16, 8'h05);
        bus_write(16'd1, 8'h00);
        wait_done(ok);
        bus_write(16'd2, 8'h93); bus_write(16'd3, 8'h02);
        bus_write(16'd1, 8'h00);
        wait_done(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL read_timeout: done never set"); end
        bus_read(16'd16, d);
        n_vec++; if (d !== 8'hAA) begin n_err++; $display("FAIL read_buf0: got %h want aa", d); end
        bus_read(16'd17, d);
        n_vec++; if (d !== 8'hBB) begin n_err++; $display("FAIL read_buf1: got %h want bb", d); end
        n_vec++; if (s_mack_n != 2 || s_mack[0] !== 1'b0 || s_mack[1] !== 1'b1)
            begin n_err++; $display("FAIL read_acks: n=%0d ack0=%b ack1=%b want 2 0 1", s_mack_n, s_mack[0], s_mack[1]); end
        bus_read(16'd1, d);
        n_vec++; if (d !== 8'h01) begin n_err++; $display("FAIL read_status: got %h want 01", d); end
    endtask

    task automatic test_nack;
        logic [7:0] d; logic ok;
        bus_write(16'd2, 8'hA0); bus_write(16'd3, 8'h02);
        bus_write(16'd1, 8'h00);
        wait_done(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL nack_timeout: done never set"); end
        bus_read(16'd1, d);
        n_vec++; if (d !== 8'h03) begin n_err++; $display("FAIL nack_status: got %h want 03", d); end
        // 8 address bits + ACK slot + SCL release inside STOP
        n_vec++; if (s_rises != 10 || !s_stop_seen) begin n_err++; $display("FAIL nack_clocks: rises=%0d stop=%b want 10 1", s_rises, s_stop_seen); end
    endtask

    task automatic test_zero_size;
        logic [7:0] d; logic ok;
        bus_write(16'd2, 8'h92); bus_write(16'd3, 8'h00);
        bus_write(16'd1, 8'h00);
        wait_done(ok);
        bus_read(16'd1, d);
        n_vec++; if (!ok || d !== 8'h01) begin n_err++; $display("FAIL zero_status: got %h ok=%b want 01", d, ok); end
        n_vec++; if (s_rises != 10 || s_rx_bytes != 0) begin n_err++; $display("FAIL zero_clocks: rises=%0d bytes=%0d want 10 0", s_rises, s_rx_bytes); end
    endtask

    task automatic test_clamp;
        logic [7:0] d; logic ok;
        bus_write(16'd2, 8'h92); bus_write(16'd3, 8'h05); bus_write(16'd4, 8'h01);
        bus_write(16'd16, 8'h20); bus_write(16'd17, 8'h01); bus_write(16'd18, 8'h02); bus_write(16'd19, 8'h03);
        bus_write(16'd1, 8'h00);
        wait_done(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL clamp_timeout: done never set"); end
        n_vec++; if (s_rx_bytes != 4) begin n_err++; $display("FAIL clamp_bytes: got %0d want 4", s_rx_bytes); end
        n_vec++; if (smem[8'h20] !== 8'h01 || smem[8'h22] !== 8'h03 || smem[8'h23] !== 8'h00)
            begin n_err++; $display("FAIL clamp_mem: got %h %h %h want 01 03 00", smem[8'h20], smem[8'h22], smem[8'h23]); end
        bus_read(16'd20, d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL buf_past_end: got %h want 00", d); end
        bus_write(16'd4, 8'h00);
    endtask

    task automatic test_abort;
        logic [7:0] d; logic ok;
        bus_write(16'd2, 8'h92); bus_write(16'd3, 8'h03);
        bus_write(16'd16, 8'h07); bus_write(16'd17, 8'h11); bus_write(16'd18, 8'h22);
        bus_write(16'd1, 8'h00);
        repeat (60) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (scl !== 1'b1 || sda !== 1'b1) begin n_err++; $display("FAIL abort_lines: scl=%b sda=%b want 1 1", scl, sda); end
        rst = 1'b0;
        bus_read(16'd1, d);
        n_vec++; if (d !== 8'h01) begin n_err++; $display("FAIL abort_status: got %h want 01", d); end
        bus_read(16'd17, d);
        n_vec++; if (d !== 8'h11) begin n_err++; $display("FAIL abort_buf_kept: got %h want 11", d); end
        bus_write(16'd2, 8'h92); bus_write(16'd3, 8'h03);
        bus_write(16'd1, 8'h00);
        wait_done(ok);
        n_vec++; if (!ok || smem[7] !== 8'h11 || smem[8] !== 8'h22)
            begin n_err++; $display("FAIL abort_rerun: ok=%b got %h %h want 11 22", ok, smem[7], smem[8]); end
        // soft reset through offset 0 mid-transfer
        bus_write(16'd1, 8'h00);
        repeat (60) @(posedge clk);
        bus_write(16'd0, 8'h5A);
        n_vec++; if (scl !== 1'b1 || sda !== 1'b1) begin n_err++; $display("FAIL soft_lines: scl=%b sda=%b want 1 1", scl, sda); end
        bus_read(16'd1, d);
        n_vec++; if (d !== 8'h01) begin n_err++; $display("FAIL soft_status: got %h want 01", d); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d; logic ok; int rises;
        bus_write(16'd2, 8'h92); bus_write(16'd3, 8'h03);
        bus_write(16'd16, 8'h10); bus_write(16'd17, 8'h33); bus_write(16'd18, 8'h44);
        bus_write(16'd1, 8'h00);
        repeat (40) @(posedge clk);
        bus_write(16'd1, 8'h00);
        bus_write(16'd16, 8'hEE);
        bus_write(16'd2, 8'h00);
        wait_done(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_timeout: done never set"); end
        n_vec++; if (s_rx_bytes != 3 || smem[8'h10] !== 8'h33 || smem[8'h11] !== 8'h44)
            begin n_err++; $display("FAIL b2b_data: bytes=%0d got %h %h want 3 33 44", s_rx_bytes, smem[8'h10], smem[8'h11]); end
        bus_read(16'd16, d);
        n_vec++; if (d !== 8'h10) begin n_err++; $display("FAIL busy_buf_write: got %h want 10", d); end
        bus_read(16'd2, d);
        n_vec++; if (d !== 8'h92) begin n_err++; $display("FAIL busy_addr_write: got %h want 92", d); end
        rises = s_rises;
        repeat (300) @(posedge clk);
        bus_read(16'd1, d);
        n_vec++; if (d !== 8'h01 || s_rises != rises) begin n_err++; $display("FAIL b2b_no_rerun: status=%h rises=%0d want 01 %0d", d, s_rises, rises); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) smem[i] = 8'h00;
        test_reset;
        test_write;
        test_read;
        test_nack;
        test_zero_size;
        test_clamp;
        test_abort;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
